// File: rtl/alu_issue_if.sv
// Handshake and operand bundle between the decode side, the issue stage and the ALU.
// The master view is the environment (upstream fetch/regfile plus downstream ALU); the slave view is the stage.
interface alu_issue_if #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              fwd_ex_en;
    logic [4:0]        fwd_ex_rd;
    logic [XLEN-1:0]   fwd_ex_data;
    logic              fwd_wb_en;
    logic [4:0]        fwd_wb_rd;
    logic [XLEN-1:0]   fwd_wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   opA;
    logic [XLEN-1:0]   opB;
    logic [SEL_W-1:0]  aluOutSel;
    logic [4:0]        rd;
    logic              illegal;

    modport master (
        output in_valid, instr, rs1_data, rs2_data,
        output fwd_ex_en, fwd_ex_rd, fwd_ex_data,
        output fwd_wb_en, fwd_wb_rd, fwd_wb_data,
        output out_ready,
        input  in_ready, out_valid, opA, opB, aluOutSel, rd, illegal
    );

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data,
        input  fwd_ex_en, fwd_ex_rd, fwd_ex_data,
        input  fwd_wb_en, fwd_wb_rd, fwd_wb_data,
        input  out_ready,
        output in_ready, out_valid, opA, opB, aluOutSel, rd, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for the RV32I ALU: decodes R/I ALU ops, resolves operands with EX/WB
// forwarding and holds them in a single valid/ready output register.
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] F7_Z = 7'b0000000;
    localparam logic [6:0] F7_A = 7'b0100000;

    localparam logic [SEL_W-1:0] SEL_ADD  = SEL_W'(4'd0);
    localparam logic [SEL_W-1:0] SEL_SUB  = SEL_W'(4'd1);
    localparam logic [SEL_W-1:0] SEL_XOR  = SEL_W'(4'd2);
    localparam logic [SEL_W-1:0] SEL_OR   = SEL_W'(4'd3);
    localparam logic [SEL_W-1:0] SEL_AND  = SEL_W'(4'd4);
    localparam logic [SEL_W-1:0] SEL_SLT  = SEL_W'(4'd5);
    localparam logic [SEL_W-1:0] SEL_SLTU = SEL_W'(4'd6);
    localparam logic [SEL_W-1:0] SEL_SLL  = SEL_W'(4'd7);
    localparam logic [SEL_W-1:0] SEL_SRL  = SEL_W'(4'd8);
    localparam logic [SEL_W-1:0] SEL_SRA  = SEL_W'(4'd9);

    // EX beats WB; x0 always reads as zero regardless of what is being forwarded.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_en,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            wb_en,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] val;
        if (idx == 5'd0) begin
            val = '0;
        end else if (ex_en && (ex_rd == idx)) begin
            val = ex_data;
        end else if (wb_en && (wb_rd == idx)) begin
            val = wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    logic [6:0]       w_opcode;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [XLEN-1:0]  w_rs1_fwd;
    logic [XLEN-1:0]  w_rs2_fwd;
    logic [XLEN-1:0]  w_imm_sext;
    logic [XLEN-1:0]  w_imm_shamt;
    logic             w_legal;
    logic [SEL_W-1:0] w_sel_raw;
    logic [XLEN-1:0]  w_opb_raw;
    logic [SEL_W-1:0] w_sel;
    logic [XLEN-1:0]  w_opa;
    logic [XLEN-1:0]  w_opb;
    logic [4:0]       w_rd;
    logic             w_in_ready;
    logic             w_capture;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_opa;
    logic [XLEN-1:0]  r_opb;
    logic [SEL_W-1:0] r_sel;
    logic [4:0]       r_rd;
    logic             r_illegal;

    assign w_opcode    = bus.instr[6:0];
    assign w_f3        = bus.instr[14:12];
    assign w_f7        = bus.instr[31:25];
    assign w_rs1       = bus.instr[19:15];
    assign w_rs2       = bus.instr[24:20];
    assign w_imm_sext  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    assign w_imm_shamt = {{(XLEN-5){1'b0}}, bus.instr[24:20]};

    assign w_rs1_fwd = fwd_operand(w_rs1, bus.rs1_data, bus.fwd_ex_en, bus.fwd_ex_rd,
                                   bus.fwd_ex_data, bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
    assign w_rs2_fwd = fwd_operand(w_rs2, bus.rs2_data, bus.fwd_ex_en, bus.fwd_ex_rd,
                                   bus.fwd_ex_data, bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);

    // Opcode/funct decode into an ALU select, raw operand B and a legality flag.
    always_comb begin
        w_legal   = 1'b0;
        w_sel_raw = SEL_ADD;
        w_opb_raw = '0;
        case (w_opcode)
            OP_R: begin
                w_opb_raw = w_rs2_fwd;
                if (w_f7 == F7_Z) begin
                    w_legal = 1'b1;
                    case (w_f3)
                        3'b000:  w_sel_raw = SEL_ADD;
                        3'b001:  w_sel_raw = SEL_SLL;
                        3'b010:  w_sel_raw = SEL_SLT;
                        3'b011:  w_sel_raw = SEL_SLTU;
                        3'b100:  w_sel_raw = SEL_XOR;
                        3'b101:  w_sel_raw = SEL_SRL;
                        3'b110:  w_sel_raw = SEL_OR;
                        3'b111:  w_sel_raw = SEL_AND;
                        default: w_sel_raw = SEL_ADD;
                    endcase
                end else if ((w_f7 == F7_A) && (w_f3 == 3'b000)) begin
                    w_legal   = 1'b1;
                    w_sel_raw = SEL_SUB;
                end else if ((w_f7 == F7_A) && (w_f3 == 3'b101)) begin
                    w_legal   = 1'b1;
                    w_sel_raw = SEL_SRA;
                end else begin
                    w_legal   = 1'b0;
                end
            end
            OP_I: begin
                w_opb_raw = w_imm_sext;
                w_legal   = 1'b1;
                case (w_f3)
                    3'b000:  w_sel_raw = SEL_ADD;
                    3'b010:  w_sel_raw = SEL_SLT;
                    3'b011:  w_sel_raw = SEL_SLTU;
                    3'b100:  w_sel_raw = SEL_XOR;
                    3'b110:  w_sel_raw = SEL_OR;
                    3'b111:  w_sel_raw = SEL_AND;
                    3'b001: begin
                        w_opb_raw = w_imm_shamt;
                        w_sel_raw = SEL_SLL;
                        w_legal   = (w_f7 == F7_Z);
                    end
                    3'b101: begin
                        w_opb_raw = w_imm_shamt;
                        w_sel_raw = (w_f7 == F7_A) ? SEL_SRA : SEL_SRL;
                        w_legal   = (w_f7 == F7_Z) || (w_f7 == F7_A);
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Illegal encodings are still issued, but with every payload field zeroed.
    always_comb begin
        if (w_legal) begin
            w_sel = w_sel_raw;
            w_opa = w_rs1_fwd;
            w_opb = w_opb_raw;
            w_rd  = bus.instr[11:7];
        end else begin
            w_sel = SEL_ADD;
            w_opa = '0;
            w_opb = '0;
            w_rd  = 5'd0;
        end
    end

    assign w_in_ready = (~r_out_valid) | bus.out_ready;
    assign w_capture  = bus.in_valid & w_in_ready;

    // Single output register: reload on capture, drain on consume, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_sel       <= '0;
            r_rd        <= 5'd0;
            r_illegal   <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_opa       <= w_opa;
            r_opb       <= w_opb;
            r_sel       <= w_sel;
            r_rd        <= w_rd;
            r_illegal   <= ~w_legal;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.opA       = r_opa;
    assign bus.opB       = r_opb;
    assign bus.aluOutSel = r_sel;
    assign bus.rd        = r_rd;
    assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage with directed corner cases and a transaction-level
// reference model of decode, forwarding and the single-entry output register.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if #(.XLEN(32), .SEL_W(4)) bus ();

    alu_issue_stage #(.XLEN(32), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic        m_valid = 1'b0;
    logic [31:0] m_a     = 32'd0;
    logic [31:0] m_b     = 32'd0;
    logic [3:0]  m_sel   = 4'd0;
    logic [4:0]  m_rd    = 5'd0;
    logic        m_ill   = 1'b0;

    // ALU select for funct7=0 R-type (and non-shift I-type), indexed by funct3.
    int r_tab [8] = '{0, 7, 5, 6, 2, 8, 3, 4};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (bus.fwd_ex_en && bus.fwd_ex_rd == idx) return bus.fwd_ex_data;
        if (bus.fwd_wb_en && bus.fwd_wb_rd == idx) return bus.fwd_wb_data;
        return rf;
    endfunction

    task automatic ref_decode(input logic [31:0] ins, output logic ill, output logic [3:0] sel,
                              output logic [31:0] a, output logic [31:0] b, output logic [4:0] rdo);
        int s;
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        s  = -1;
        b  = 32'd0;
        if (ins[6:0] == 7'h33) begin
            b = ref_fwd(ins[24:20], bus.rs2_data);
            if (f7 == 7'h00) s = r_tab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) s = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) s = 9;
        end else if (ins[6:0] == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                b = {27'd0, ins[24:20]};
                if (f3 == 3'd1 && f7 == 7'h00) s = 7;
                if (f3 == 3'd5 && f7 == 7'h00) s = 8;
                if (f3 == 3'd5 && f7 == 7'h20) s = 9;
            end else begin
                b = {{20{ins[31]}}, ins[31:20]};
                s = r_tab[f3];
            end
        end
        if (s < 0) begin
            ill = 1'b1; sel = 4'd0; a = 32'd0; b = 32'd0; rdo = 5'd0;
        end else begin
            ill = 1'b0; sel = s[3:0]; a = ref_fwd(ins[19:15], bus.rs1_data); rdo = ins[11:7];
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic step();
        logic        cap;
        logic        d_ill;
        logic [3:0]  d_sel;
        logic [31:0] d_a;
        logic [31:0] d_b;
        logic [4:0]  d_rd;
        logic        was_rst;
        #1;
        if (!rst) check_eq("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_valid || bus.out_ready)});
        cap     = bus.in_valid && (!m_valid || bus.out_ready);
        was_rst = rst;
        ref_decode(bus.instr, d_ill, d_sel, d_a, d_b, d_rd);
        @(posedge clk);
        if (was_rst) begin
            m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_sel = 4'd0; m_rd = 5'd0; m_ill = 1'b0;
        end else if (cap) begin
            m_valid = 1'b1; m_a = d_a; m_b = d_b; m_sel = d_sel; m_rd = d_rd; m_ill = d_ill;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_eq("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        check_eq("opA", bus.opA, m_a);
        check_eq("opB", bus.opB, m_b);
        check_eq("aluOutSel", {28'd0, bus.aluOutSel}, {28'd0, m_sel});
        check_eq("rd", {27'd0, bus.rd}, {27'd0, m_rd});
        check_eq("illegal", {31'd0, bus.illegal}, {31'd0, m_ill});
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ordy);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.rs1_data  = r1;
        bus.rs2_data  = r2;
        bus.out_ready = ordy;
    endtask

    task automatic set_fwd(input logic ee, input logic [4:0] erd, input logic [31:0] ed,
                           input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        bus.fwd_ex_en = ee; bus.fwd_ex_rd = erd; bus.fwd_ex_data = ed;
        bus.fwd_wb_en = we; bus.fwd_wb_rd = wrd; bus.fwd_wb_data = wd;
    endtask

    function automatic logic [31:0] rand_instr();
        int          r;
        int          p;
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        r = $urandom_range(0, 9);
        if (r < 4) op = 7'h33;
        else if (r < 8) op = 7'h13;
        else if (r == 8) op = 7'h63;
        else op = 7'($urandom);
        p = $urandom_range(0, 3);
        if (p <= 1) f7 = 7'h00;
        else if (p == 2) f7 = 7'h20;
        else f7 = 7'($urandom);
        f3 = 3'($urandom);
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3, 5'($urandom), op};
    endfunction

    initial begin
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_opA", bus.opA, 32'd0);

        drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1);
        step();
        check_eq("add_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("add_opA", bus.opA, 32'd5);
        check_eq("add_opB", bus.opB, 32'd7);
        check_eq("add_sel", {28'd0, bus.aluOutSel}, 32'd0);
        check_eq("add_rd", {27'd0, bus.rd}, 32'd3);

        drive(1'b1, 32'h40435293, 32'h80000000, 32'd0, 1'b1);
        step();
        check_eq("srai_sel", {28'd0, bus.aluOutSel}, 32'd9);
        check_eq("srai_opA", bus.opA, 32'h80000000);
        check_eq("srai_opB", bus.opB, 32'd4);
        drive(1'b1, 32'hFFF00093, 32'h00001234, 32'd0, 1'b1);
        step();
        check_eq("addi_opA", bus.opA, 32'd0);
        check_eq("addi_opB", bus.opB, 32'hFFFFFFFF);

        set_fwd(1'b1, 5'd1, 32'hAA, 1'b1, 5'd1, 32'hBB);
        drive(1'b1, 32'h40208233, 32'h11, 32'h22, 1'b1);
        step();
        check_eq("fwd_ex_wins", bus.opA, 32'hAA);
        check_eq("fwd_rf_rs2", bus.opB, 32'h22);
        check_eq("sub_sel", {28'd0, bus.aluOutSel}, 32'd1);
        set_fwd(1'b1, 5'd1, 32'hAA, 1'b1, 5'd2, 32'hBB);
        step();
        check_eq("fwd_wb_rs2", bus.opB, 32'hBB);
        set_fwd(1'b1, 5'd0, 32'hCC, 1'b1, 5'd0, 32'hDD);
        drive(1'b1, 32'h40200233, 32'h11, 32'h22, 1'b1);
        step();
        check_eq("fwd_x0", bus.opA, 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h002081B3 + (32'(i) << 7), 32'd100 + 32'(i), 32'd9, 1'b0);
            step();
            check_eq("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check_eq("stall_opA", bus.opA, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h002081B3, 32'd200 + 32'(i), 32'd1, 1'b1);
            step();
            check_eq("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
            check_eq("b2b_opA", bus.opA, 32'd200 + 32'(i));
        end

        drive(1'b1, 32'h00000063, 32'd1, 32'd2, 1'b1);
        step();
        check_eq("br_illegal", {31'd0, bus.illegal}, 32'd1);
        check_eq("br_rd", {27'd0, bus.rd}, 32'd0);
        drive(1'b1, 32'h022081B3, 32'd1, 32'd2, 1'b1);
        step();
        check_eq("mul_illegal", {31'd0, bus.illegal}, 32'd1);
        check_eq("mul_sel", {28'd0, bus.aluOutSel}, 32'd0);
        check_eq("mul_opB", bus.opB, 32'd0);
        drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_flush", {31'd0, bus.out_valid}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            drive(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0));
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
